// File: rtl/memory_sequencer.sv
// Wishbone classic bus-master sequencer: one load/store at a time, split across two beats when needed.
// Optional feature: define MEMORY_SEQUENCER_MISALIGNED_SPLIT_EN to split lane-crossing misaligned accesses.
module memory_sequencer #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [1:0]              req_size,
    input  logic                    req_signed,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [31:0]             req_wdata,
    output logic                    resp_valid,
    output logic [31:0]             resp_rdata,
    output logic                    resp_error,
    output logic [3:0]              resp_cause,
    output logic [ADDR_WIDTH-1:0]   adr_o,
    output logic [DATA_WIDTH-1:0]   dat_o,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    output logic [DATA_WIDTH/8-1:0] sel_o,
    output logic                    we_o,
    output logic                    cyc_o,
    output logic                    stb_o,
    input  logic                    ack_i,
    input  logic                    err_i,
    output logic [1:0]              dbg_state
);
    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // the response is a single-cycle resp_valid pulse with no back-pressure.
    localparam int LANES = DATA_WIDTH / 8;
    localparam int LB    = $clog2(LANES);
    localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2, RESP = 2'd3} state_t;
    state_t state;

    logic                    lat_write;
    logic [1:0]              lat_size;
    logic                    lat_signed;
    logic [LB-1:0]           lat_off;
    logic                    two_beat;
    logic [ADDR_WIDTH-1:0]   beat1_adr;
    logic [DATA_WIDTH-1:0]   beat1_dat;
    logic [LANES-1:0]        beat1_sel;
    logic [DATA_WIDTH-1:0]   rbuf_lo;
    logic [TW-1:0]           tmo_cnt;

    // Request-side lane math, evaluated on the raw request in IDLE.
    logic [LB-1:0]           off;
    logic [3:0]              byte_mask;
    logic [31:0]             wdata_m;
    logic [2*LANES-1:0]      wide_sel;
    logic [2*DATA_WIDTH-1:0] wide_dat;
    logic                    misaligned;
    logic                    crosses;
    logic [ADDR_WIDTH-1:0]   base_adr;

    always_comb begin
        off       = req_addr[LB-1:0];
        base_adr  = {req_addr[ADDR_WIDTH-1:LB], {LB{1'b0}}};
        case (req_size)
            2'd0:    byte_mask = 4'b0001;
            2'd1:    byte_mask = 4'b0011;
            default: byte_mask = 4'b1111;
        endcase
        wdata_m    = req_wdata & {{8{byte_mask[3]}}, {8{byte_mask[2]}}, {8{byte_mask[1]}}, {8{byte_mask[0]}}};
        wide_sel   = {{(2*LANES-4){1'b0}}, byte_mask} << off;
        wide_dat   = {{(2*DATA_WIDTH-32){1'b0}}, wdata_m} << {off, 3'b000};
        misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                     ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
        crosses    = |wide_sel[2*LANES-1:LANES];
    end

    // Load result: beat1 bytes sit above beat0 bytes, then shift down by the lane offset.
    logic [2*DATA_WIDTH-1:0] merged;
    logic [31:0]             load_raw;
    logic [31:0]             load_data;
    logic                    timeout_hit;

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] size, input logic sgn);
        case (size)
            2'd0:    return {{24{sgn & v[7]}}, v[7:0]};
            2'd1:    return {{16{sgn & v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    always_comb begin
        merged      = (state == BEAT1) ? {dat_i, rbuf_lo} : {{DATA_WIDTH{1'b0}}, dat_i};
        load_raw    = merged[{lat_off, 3'b000} +: 32];
        load_data   = extend(load_raw, lat_size, lat_signed);
        timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);
    end

    assign req_ready = (state == IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
            resp_cause <= '0;
            adr_o      <= '0;
            dat_o      <= '0;
            sel_o      <= '0;
            we_o       <= 1'b0;
            cyc_o      <= 1'b0;
            stb_o      <= 1'b0;
            tmo_cnt    <= '0;
            lat_write  <= 1'b0;
            lat_size   <= '0;
            lat_signed <= 1'b0;
            lat_off    <= '0;
            two_beat   <= 1'b0;
            beat1_adr  <= '0;
            beat1_dat  <= '0;
            beat1_sel  <= '0;
            rbuf_lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write  <= req_write;
                        lat_size   <= req_size;
                        lat_signed <= req_signed;
                        lat_off    <= off;
                        beat1_adr  <= base_adr + ADDR_WIDTH'(LANES);
                        beat1_dat  <= wide_dat[2*DATA_WIDTH-1:DATA_WIDTH];
                        beat1_sel  <= wide_sel[2*LANES-1:LANES];
`ifdef MEMORY_SEQUENCER_MISALIGNED_SPLIT_EN
                        two_beat   <= crosses;
`else
                        two_beat   <= 1'b0;
`endif
                        if (req_size == 2'd3) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_cause <= 4'd2;
`ifndef MEMORY_SEQUENCER_MISALIGNED_SPLIT_EN
                        end else if (misaligned) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_cause <= req_write ? 4'd6 : 4'd4;
`endif
                        end else begin
                            state   <= BEAT0;
                            adr_o   <= base_adr;
                            dat_o   <= wide_dat[DATA_WIDTH-1:0];
                            sel_o   <= wide_sel[LANES-1:0];
                            we_o    <= req_write;
                            cyc_o   <= 1'b1;
                            stb_o   <= 1'b1;
                            tmo_cnt <= '0;
                        end
                    end
                end
                BEAT0, BEAT1: begin
                    if (err_i || (!ack_i && timeout_hit)) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b1;
                        resp_cause <= lat_write ? 4'd7 : 4'd5;
                        resp_rdata <= '0;
                        {adr_o, dat_o, sel_o, we_o, cyc_o, stb_o} <= '0;
                    end else if (ack_i) begin
                        if ((state == BEAT0) && two_beat) begin
                            state   <= BEAT1;
                            rbuf_lo <= dat_i;
                            adr_o   <= beat1_adr;
                            dat_o   <= beat1_dat;
                            sel_o   <= beat1_sel;
                            tmo_cnt <= '0;
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b0;
                            resp_cause <= '0;
                            resp_rdata <= lat_write ? 32'd0 : load_data;
                            {adr_o, dat_o, sel_o, we_o, cyc_o, stb_o} <= '0;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    resp_error <= 1'b0;
                    resp_cause <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_sequencer.sv
// Directed bench for memory_sequencer (DATA_WIDTH=32, TIMEOUT_CYCLES=4); covers both split configurations.
module tb_memory_sequencer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_error;
    logic [31:0] resp_rdata;
    logic [3:0]  resp_cause;
    logic [31:0] adr_o, dat_o, dat_i;
    logic [3:0]  sel_o;
    logic        we_o, cyc_o, stb_o, ack_i, err_i;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    memory_sequencer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error), .resp_cause(resp_cause),
        .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .sel_o(sel_o), .we_o(we_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .ack_i(ack_i), .err_i(err_i), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for exactly one edge; caller has confirmed req_ready.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic ack_with(input logic [31:0] d);
        dat_i = d; ack_i = 1'b1;
        tick();
        ack_i = 1'b0; dat_i = '0;
    endtask

    initial begin
        int  stb_cycles;
        bit  got;
        reset_n = 1'b0; req_valid = 0; req_write = 0; req_size = 0; req_signed = 0;
        req_addr = 0; req_wdata = 0; dat_i = 0; ack_i = 0; err_i = 0;
        repeat (3) tick();
        check("rst_ready", req_ready, 1);
        check("rst_stb_cyc", {stb_o, cyc_o}, 0);
        check("rst_resp", {resp_valid, resp_error, resp_cause, resp_rdata}, 0);
        check("rst_bus", {adr_o, sel_o, we_o}, 0);
        check("rst_state", dbg_state, 0);
        reset_n = 1'b1;
        tick();

        // LW at 0x100, acked in first cycle
        check("lw_ready", req_ready, 1);
        issue(0, 2'd2, 0, 32'h100, 0);
        check("lw_stb_cyc", {stb_o, cyc_o, we_o}, 3'b110);
        check("lw_adr", adr_o, 32'h100);
        check("lw_sel", sel_o, 4'b1111);
        check("lw_no_resp_yet", resp_valid, 0);
        ack_with(32'h8765_4321);
        check("lw_resp", {resp_valid, resp_error}, 2'b10);
        check("lw_rdata", resp_rdata, 32'h8765_4321);
        check("lw_stb_off", stb_o, 0);
        tick();
        check("lw_back_idle", {resp_valid, req_ready}, 2'b01);

        // LB signed at 0x101: byte1 = 0x9C
        issue(0, 2'd0, 1, 32'h101, 0);
        check("lb_sel", sel_o, 4'b0010);
        ack_with(32'h0000_9C00);
        check("lb_rdata", resp_rdata, 32'hFFFF_FF9C);
        tick();

        // Reserved size
        issue(0, 2'd3, 0, 32'h100, 0);
        check("rsv_resp", {resp_valid, resp_error, stb_o}, 3'b110);
        check("rsv_cause", resp_cause, 4'd2);
        tick();

`ifdef MEMORY_SEQUENCER_MISALIGNED_SPLIT_EN
        // LH signed at 0x103 crosses the lane boundary
        issue(0, 2'd1, 1, 32'h103, 0);
        check("lh_b0_adr", adr_o, 32'h100);
        check("lh_b0_sel", sel_o, 4'b1000);
        ack_with(32'hF011_2233);
        check("lh_b1_state", {dbg_state, stb_o}, {2'd2, 1'b1});
        check("lh_b1_adr", adr_o, 32'h104);
        check("lh_b1_sel", sel_o, 4'b0001);
        check("lh_b1_no_resp", resp_valid, 0);
        ack_with(32'h4455_6680);
        check("lh_resp", {resp_valid, resp_error}, 2'b10);
        check("lh_rdata", resp_rdata, 32'hFFFF_80F0);
        tick();

        // SH at 0x201 stays inside one word
        issue(1, 2'd1, 0, 32'h201, 32'h0000_BEEF);
        check("sh_sel", sel_o, 4'b0110);
        check("sh_dat", {we_o, dat_o}, {1'b1, 32'h00BE_EF00});
        ack_with(0);
        check("sh_resp", {resp_valid, resp_error, resp_rdata}, {2'b10, 32'h0});
        tick();
`else
        // LH signed at 0x103 rejected without a bus cycle
        issue(0, 2'd1, 1, 32'h103, 0);
        check("lh_mis_stb", {stb_o, cyc_o}, 0);
        check("lh_mis_resp", {resp_valid, resp_error}, 2'b11);
        check("lh_mis_cause", resp_cause, 4'd4);
        check("lh_mis_rdata", resp_rdata, 0);
        tick();

        issue(1, 2'd1, 0, 32'h201, 32'h0000_BEEF);
        check("sh_mis_stb", stb_o, 0);
        check("sh_mis_cause", {resp_valid, resp_error, resp_cause}, {2'b11, 4'd6});
        tick();
`endif

        // SB 0xAB at 0x202 with no ack: timeout after 4 strobe cycles
        issue(1, 2'd0, 0, 32'h202, 32'h1234_56AB);
        check("sb_sel", sel_o, 4'b0100);
        check("sb_dat", dat_o[23:16], 8'hAB);
        stb_cycles = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (stb_o) stb_cycles++;
            if (resp_valid) got = 1;
            else tick();
        end
        check("sb_tmo_resp_seen", got, 1);
        check("sb_tmo_stb_cycles", stb_cycles, 4);
        check("sb_tmo_cause", {resp_error, resp_cause}, {1'b1, 4'd7});
        tick();

        // SW at 0x300 with ack and err together; back-to-back request held valid
        issue(1, 2'd2, 0, 32'h300, 32'hCAFE_F00D);
        ack_i = 1'b1; err_i = 1'b1;
        tick();
        ack_i = 1'b0; err_i = 1'b0;
        check("sw_err_cause", {resp_valid, resp_error, resp_cause}, {2'b11, 4'd7});
        check("sw_resp_not_ready", req_ready, 0);
        req_write = 0; req_size = 2'd2; req_signed = 0; req_addr = 32'h400; req_valid = 1'b1;
        tick();
        check("next_ready_after_resp", {req_ready, stb_o, resp_valid}, 3'b100);
        tick();
        req_valid = 1'b0;
        check("next_accepted", {stb_o, adr_o}, {1'b1, 32'h400});
        ack_with(32'h1357_9BDF);
        check("next_rdata", {resp_valid, resp_rdata}, {1'b1, 32'h1357_9BDF});
        tick();

        // Reset in the middle of a bus beat
`ifdef MEMORY_SEQUENCER_MISALIGNED_SPLIT_EN
        issue(0, 2'd2, 0, 32'h102, 0);
        ack_with(32'hAAAA_BBBB);
        check("rst_mid_state", dbg_state, 2'd2);
`else
        issue(0, 2'd2, 0, 32'h100, 0);
        check("rst_mid_state", dbg_state, 2'd1);
`endif
        reset_n = 1'b0;
        #1;
        check("rst_mid_drop", {stb_o, cyc_o, dbg_state}, 0);
        got = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (resp_valid) got = 1;
        end
        reset_n = 1'b1;
        tick();
        if (resp_valid) got = 1;
        check("rst_mid_no_resp", got, 0);
        check("rst_mid_ready", {req_ready, stb_o}, 2'b10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
